// File: rtl/sha1_pkg.sv
// sha1_pkg: shared widths, pad constants and FSM state codes
// for the SHA-1 message padder.
package sha1_pkg;

  localparam int BLK_W       = 512;
  localparam int WORD_W      = 32;
  localparam int LEN_FIELD_W = 64;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef logic [2:0] state_t;

  localparam state_t ST_FILL    = 3'd0;
  localparam state_t ST_SEND    = 3'd1;
  localparam state_t ST_START   = 3'd2;
  localparam state_t ST_WAIT_HI = 3'd3;
  localparam state_t ST_WAIT_LO = 3'd4;
  localparam state_t ST_EXTRA   = 3'd5;

  // A zero count only means "empty" on a sole first word.
  function automatic logic [2:0] eff_bytes(
    input logic [2:0] nb,
    input logic       mid
  );
    if (nb == 3'd0) return mid ? 3'd4 : 3'd0;
    if (nb > 3'd4) return 3'd4;
    return nb;
  endfunction

endpackage

// File: rtl/sha1_pad_word.sv
// sha1_pad_word: keeps the leading k bytes of a big-endian word
// and drops the 0x80 marker into byte k when k < 4.
module sha1_pad_word
  import sha1_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic [2:0]        bytes,
  output logic [WORD_W-1:0] word
);

  always_comb begin
    word = '0;
    for (int j = 0; j < 4; j++) begin
      if (j < int'(bytes))
        word[31-8*j -: 8] = data[31-8*j -: 8];
      else if (j == int'(bytes))
        word[31-8*j -: 8] = PAD_BYTE;
    end
  end

endmodule

// File: rtl/sha1_msg_padder.sv
// sha1_msg_padder: packs a 32-bit message stream into padded
// SHA-1 blocks; SHA1_PAD_BLKCNT_EN adds a blk_cnt output.
module sha1_msg_padder
  import sha1_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  input  logic [2:0]       s_bytes,
  input  logic             core_busy,
  output logic             core_start,
  output logic             core_use_prev_cv,
  output logic [BLK_W-1:0] core_data,
  output logic             msg_done
`ifdef SHA1_PAD_BLKCNT_EN
  ,
  output logic [15:0]      blk_cnt
`endif
);

  state_t                   state_q, state_d;
  logic [0:15][WORD_W-1:0]  blk_q, blk_d;
  logic [3:0]               widx_q, widx_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic                     first_q, first_d;
  logic                     final_q, final_d;
  logic                     extra_q, extra_d;
  logic                     x80_q, x80_d;
  logic                     rdy_q;

  logic                     acc;
  logic [2:0]               k;
  logic [5:0]               len_add;
  logic [LEN_W-1:0]         len_sum;
  logic [LEN_FIELD_W-1:0]   lf_sum;
  logic [LEN_FIELD_W-1:0]   lf_cur;
  logic [6:0]               b;
  logic [WORD_W-1:0]        pad_w;

  assign acc     = s_valid & rdy_q;
  assign k       = eff_bytes(s_bytes, widx_q != 4'd0);
  assign len_add = s_last ? {k, 3'b000} : 6'd32;
  assign len_sum = len_q + LEN_W'(len_add);
  assign lf_sum  = LEN_FIELD_W'(len_sum);
  assign lf_cur  = LEN_FIELD_W'(len_q);
  assign b       = {1'b0, widx_q, 2'b00} + {4'b0000, k};

  sha1_pad_word u_pad (
    .data  (s_data),
    .bytes (k),
    .word  (pad_w)
  );

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    widx_d  = widx_q;
    len_d   = len_q;
    first_d = first_q;
    final_d = final_q;
    extra_d = extra_q;
    x80_d   = x80_q;
    unique case (state_q)
      ST_FILL: begin
        if (acc && !s_last) begin
          blk_d[widx_q] = s_data;
          widx_d = widx_q + 4'd1;
          len_d  = len_sum;
          if (widx_q == 4'd15) begin
            state_d = ST_SEND;
            final_d = 1'b0;
          end
        end else if (acc) begin
          // Marker spills into the next word on a full last word.
          for (int i = 0; i < 16; i++) begin
            if (i == int'(widx_q))
              blk_d[i] = pad_w;
            else if (i == int'(widx_q) + 1 && k == 3'd4)
              blk_d[i] = {PAD_BYTE, 24'h0};
            else if (i > int'(widx_q))
              blk_d[i] = '0;
          end
          widx_d  = '0;
          len_d   = len_sum;
          state_d = ST_SEND;
          if (b <= 7'd55) begin
            final_d   = 1'b1;
            blk_d[14] = lf_sum[63:32];
            blk_d[15] = lf_sum[31:0];
          end else begin
            final_d = 1'b0;
            extra_d = 1'b1;
            x80_d   = (b == 7'd64);
          end
        end
      end
      ST_SEND: begin
        if (!core_busy) state_d = ST_START;
      end
      ST_START: begin
        first_d = 1'b0;
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (core_busy) state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!core_busy) begin
          if (extra_q) begin
            state_d = ST_EXTRA;
          end else if (final_q) begin
            state_d = ST_FILL;
            blk_d   = '0;
            len_d   = '0;
            widx_d  = '0;
            first_d = 1'b1;
            final_d = 1'b0;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_EXTRA: begin
        blk_d     = '0;
        blk_d[0]  = x80_q ? {PAD_BYTE, 24'h0} : '0;
        blk_d[14] = lf_cur[63:32];
        blk_d[15] = lf_cur[31:0];
        final_d   = 1'b1;
        extra_d   = 1'b0;
        x80_d     = 1'b0;
        state_d   = ST_SEND;
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      blk_q   <= '0;
      widx_q  <= '0;
      len_q   <= '0;
      first_q <= 1'b1;
      final_q <= 1'b0;
      extra_q <= 1'b0;
      x80_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      widx_q  <= widx_d;
      len_q   <= len_d;
      first_q <= first_d;
      final_q <= final_d;
      extra_q <= extra_d;
      x80_q   <= x80_d;
      rdy_q   <= (state_d == ST_FILL);
    end
  end

  assign s_ready          = rdy_q;
  assign core_start       = (state_q == ST_START);
  assign core_use_prev_cv = core_start & ~first_q;
  assign msg_done         = core_start & final_q;
  assign core_data        = blk_q;

`ifdef SHA1_PAD_BLKCNT_EN
  logic done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt <= '0;
      done_d  <= 1'b0;
    end else begin
      done_d <= msg_done;
      if (done_d)
        blk_cnt <= '0;
      else if (core_start && blk_cnt != 16'hFFFF)
        blk_cnt <= blk_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha1_msg_padder.sv
// tb_sha1_msg_padder: byte-level padding model plus a SHA-1
// core model that checks every issued block and digest.
module tb_sha1_msg_padder;

  localparam logic [159:0] H0 =
    160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  typedef struct {
    logic [511:0] d;
    logic         upc;
    logic         done;
    int           cyc;
  } cap_t;

  logic         clk = 0;
  logic         rst = 1;
  logic         s_valid = 0;
  logic         s_ready;
  logic [31:0]  s_data = 0;
  logic         s_last = 0;
  logic [2:0]   s_bytes = 0;
  logic         core_busy;
  logic         core_start;
  logic         core_use_prev_cv;
  logic [511:0] core_data;
  logic         msg_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_cyc = 0;
  int busy_lo = 2;
  int busy_hi = 5;
  int bcnt = 0;
  logic busy_m = 0;
  logic hold = 0;
  logic [159:0] cv = 0;
  cap_t mc;
  cap_t caps[$];
  logic [511:0] exp_q[$];
  logic [159:0] dig_q[$];

  assign core_busy = busy_m | hold;

  sha1_msg_padder dut (
    .clk              (clk),
    .rst              (rst),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_data           (s_data),
    .s_last           (s_last),
    .s_bytes          (s_bytes),
    .core_busy        (core_busy),
    .core_start       (core_start),
    .core_use_prev_cv (core_use_prev_cv),
    .core_data        (core_data),
    .msg_done         (msg_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] sha1_f(
    input logic [159:0] h, input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    {a, b, c, d, e} = h;
    for (int i = 0; i < 80; i++) begin
      if (i < 20) begin
        f = (b & c) | (~b & d); k = 32'h5A827999;
      end else if (i < 40) begin
        f = b ^ c ^ d; k = 32'h6ED9EBA1;
      end else if (i < 60) begin
        f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC;
      end else begin
        f = b ^ c ^ d; k = 32'hCA62C1D6;
      end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c,
            h[63:32] + d, h[31:0] + e};
  endfunction

  // Reference padding: append 0x80, zero to 56 mod 64, bit length.
  function automatic void pad_ref(input bit [7:0] m[$],
                                  output logic [511:0] q[$]);
    bit [7:0] p[$];
    logic [63:0] bl;
    logic [511:0] x;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(m.size()) << 3;
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    q = {};
    for (int bk = 0; bk < p.size() / 64; bk++) begin
      for (int j = 0; j < 64; j++) x[511-8*j -: 8] = p[64*bk+j];
      q.push_back(x);
    end
  endfunction

  function automatic void s2q(input string s, output bit [7:0] q[$]);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endfunction

  function automatic void rnd_msg(input int n, output bit [7:0] q[$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endfunction

  // Core model: captures each start, stays busy a random while.
  always @(negedge clk) begin
    if (rst) begin
      busy_m = 0;
      bcnt = 0;
    end else begin
      if (bcnt > 0) begin
        if (caps.size() > 0 && caps.size() <= exp_q.size())
          chk("stable", core_data, exp_q[caps.size()-1]);
        bcnt--;
        if (bcnt == 0) busy_m = 0;
      end
      if (core_start) begin
        mc.d = core_data;
        mc.upc = core_use_prev_cv;
        mc.done = msg_done;
        mc.cyc = cyc;
        caps.push_back(mc);
        cv = sha1_f(core_use_prev_cv ? cv : H0, core_data);
        if (msg_done) dig_q.push_back(cv);
        busy_m = 1;
        bcnt = $urandom_range(busy_hi, busy_lo);
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!s_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("ready", s_ready, 1);
  endtask

  task automatic begin_msg(input bit [7:0] m[$]);
    pad_ref(m, exp_q);
    caps = {};
    dig_q = {};
  endtask

  task automatic send_msg(input bit [7:0] m[$], input bit gaps);
    int n = m.size();
    int nw = (n == 0) ? 1 : (n + 3) / 4;
    int nb;
    logic [31:0] d;
    for (int w = 0; w < nw; w++) begin
      d = $urandom;
      nb = n - 4 * w;
      if (nb > 4) nb = 4;
      for (int j = 0; j < 4; j++)
        if (j < nb) d[31-8*j -: 8] = m[4*w+j];
      if (gaps) repeat ($urandom_range(2, 0)) @(negedge clk);
      wait_ready();
      s_valid = 1;
      s_data = d;
      s_last = (w == nw - 1);
      s_bytes = 3'($urandom_range(7, 0));
      if (s_last) begin
        s_bytes = 3'(nb);
        if (nb == 4 && w > 0 && $urandom_range(1, 0) == 1)
          s_bytes = 3'd0;
        last_cyc = cyc;
      end
      @(negedge clk);
      s_valid = 0;
      s_last = 0;
      s_data = $urandom;
      s_bytes = 3'($urandom_range(7, 0));
    end
  endtask

  task automatic end_msg(input bit cd, input logic [159:0] dig,
                         input int exp_sc);
    int t = 0;
    int fi = -1;
    while (dig_q.size() == 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("msgdone", dig_q.size(), 1);
    chk("nblk", caps.size(), exp_q.size());
    for (int i = 0; i < caps.size() && i < exp_q.size(); i++) begin
      chk("blk", caps[i].d, exp_q[i]);
      chk("upc", caps[i].upc, i != 0);
      chk("done", caps[i].done, i == exp_q.size() - 1);
    end
    for (int i = caps.size() - 1; i >= 0; i--)
      if (caps[i].cyc > last_cyc) fi = i;
    chk("lat_found", fi >= 0, 1);
    if (fi >= 0)
      chk("lat", caps[fi].cyc, (exp_sc < 0) ? last_cyc + 2 : exp_sc);
    if (cd && dig_q.size() > 0) chk("digest", dig_q[0], dig);
  endtask

  initial begin
    bit [7:0] m[$];
    int lens[15] = '{1, 3, 4, 52, 53, 54, 56, 57, 59, 60,
                     63, 65, 119, 120, 128};
    int t;
    int mcyc;

    repeat (3) @(negedge clk);
    chk("rst_rdy", s_ready, 0);
    chk("rst_start", core_start, 0);
    chk("rst_upc", core_use_prev_cv, 0);
    chk("rst_done", msg_done, 0);
    chk("rst_data", core_data, 0);
    rst = 0;
    #1 chk("rdy_early", s_ready, 0);
    @(negedge clk);
    chk("rdy_up", s_ready, 1);

    s2q("abc", m);
    begin_msg(m);
    send_msg(m, 0);
    end_msg(1, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d, -1);

    s2q({"abcdbcdecdefdefgefghfghighijhijkijkl",
         "jklmklmnlmnomnopnopq"}, m);
    begin_msg(m);
    send_msg(m, 0);
    end_msg(1, 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1, -1);

    m = {};
    begin_msg(m);
    send_msg(m, 0);
    end_msg(1, 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709, -1);

    rnd_msg(55, m);
    begin_msg(m);
    send_msg(m, 1);
    end_msg(0, 0, -1);

    rnd_msg(64, m);
    begin_msg(m);
    send_msg(m, 1);
    end_msg(0, 0, -1);

    for (int i = 0; i < 15; i++) begin
      rnd_msg(lens[i], m);
      begin_msg(m);
      send_msg(m, 1);
      end_msg(0, 0, -1);
    end
    for (int i = 0; i < 4; i++) begin
      rnd_msg($urandom_range(200, 0), m);
      begin_msg(m);
      send_msg(m, 1);
      end_msg(0, 0, -1);
    end

    hold = 1;
    s2q("abc", m);
    begin_msg(m);
    send_msg(m, 0);
    repeat (20) begin
      chk("hold_rdy", s_ready, 0);
      chk("hold_start", core_start, 0);
      chk("hold_data", core_data, exp_q[0]);
      @(negedge clk);
    end
    hold = 0;
    mcyc = cyc;
    end_msg(1, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d,
            mcyc + 1);

    busy_lo = 8;
    busy_hi = 8;
    rnd_msg(64, m);
    begin_msg(m);
    send_msg(m, 0);
    t = 0;
    while (caps.size() == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("mid_start", caps.size(), 1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("mid_rdy", s_ready, 0);
    chk("mid_start0", core_start, 0);
    chk("mid_upc", core_use_prev_cv, 0);
    chk("mid_done", msg_done, 0);
    chk("mid_data", core_data, 0);
    repeat (2) @(negedge clk);
    chk("mid_nostart", caps.size(), 1);
    rst = 0;
    busy_lo = 2;
    busy_hi = 5;
    @(negedge clk);
    chk("mid_rdy_up", s_ready, 1);
    s2q("abc", m);
    begin_msg(m);
    send_msg(m, 0);
    end_msg(1, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
